// File: rtl/ram_port_arbiter.sv
//==============================================================================
// Module   : ram_port_arbiter
// Brief    : Round-robin arbiter sharing one single-port RAM between two
//            req/ack requesters. One read or write per transaction; read data
//            is returned in a per-port holding register alongside the ack.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module ram_port_arbiter #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 16,
    parameter int RD_LAT = 2
) (
    input  logic              i_CLK,
    input  logic              i_RST_N,
    input  logic              i_REQ0,
    input  logic              i_REQ1,
    input  logic              i_WE0,
    input  logic              i_WE1,
    input  logic [ADDR_W-1:0] i_ADDR0,
    input  logic [ADDR_W-1:0] i_ADDR1,
    input  logic [DATA_W-1:0] i_WDATA0,
    input  logic [DATA_W-1:0] i_WDATA1,
    output logic              o_ACK0,
    output logic              o_ACK1,
    output logic [DATA_W-1:0] o_RDATA0,
    output logic [DATA_W-1:0] o_RDATA1,
    output logic [ADDR_W-1:0] o_MEM_ADDR,
    output logic [DATA_W-1:0] o_MEM_DATA,
    output logic              o_MEM_WREN,
    output logic              o_MEM_RDEN,
    input  logic [DATA_W-1:0] i_MEM_Q,
    output logic              o_BUSY,
    output logic              o_GNT
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WR   = 2'd1,
        S_RD   = 2'd2,
        S_ACK  = 2'd3
    } state_t;

    // Wait-counter value on the edge that samples the RAM output (RD_LAT 1..4).
    localparam logic [1:0] c_WAIT_LAST = 2'(RD_LAT - 1);

    state_t            r_state;
    logic [1:0]        r_wait;
    // Set by the first grant after reset. Until then o_GNT (reset 0) is not a
    // real history, and a tie must go to port 0 rather than "not o_GNT".
    logic              r_gnt_valid;

    logic              w_any;
    logic              w_win;
    logic              w_we;
    logic [ADDR_W-1:0] w_addr;
    logic [DATA_W-1:0] w_wdata;

    // Winner selection: lone requester wins, a tie goes to the port not last granted.
    always_comb begin
        w_any   = i_REQ0 | i_REQ1;
        w_win   = (i_REQ0 & i_REQ1) ? (r_gnt_valid ? ~o_GNT : 1'b0) : i_REQ1;
        w_we    = w_win ? i_WE1    : i_WE0;
        w_addr  = w_win ? i_ADDR1  : i_ADDR0;
        w_wdata = w_win ? i_WDATA1 : i_WDATA0;
    end

    // Transaction FSM; every output is a register updated here.
    always_ff @(posedge i_CLK or negedge i_RST_N) begin
        if (!i_RST_N) begin
            r_state     <= S_IDLE;
            r_wait      <= 2'd0;
            r_gnt_valid <= 1'b0;
            o_ACK0      <= 1'b0;
            o_ACK1      <= 1'b0;
            o_RDATA0    <= '0;
            o_RDATA1    <= '0;
            o_MEM_ADDR  <= '0;
            o_MEM_DATA  <= '0;
            o_MEM_WREN  <= 1'b0;
            o_MEM_RDEN  <= 1'b0;
            o_BUSY      <= 1'b0;
            o_GNT       <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_any) begin
                        o_GNT       <= w_win;
                        r_gnt_valid <= 1'b1;
                        o_MEM_ADDR  <= w_addr;
                        o_MEM_DATA  <= w_wdata;
                        o_MEM_WREN  <= w_we;
                        o_MEM_RDEN  <= ~w_we;
                        o_BUSY      <= 1'b1;
                        r_wait      <= 2'd0;
                        r_state     <= w_we ? S_WR : S_RD;
                    end
                end
                S_WR: begin
                    o_MEM_WREN <= 1'b0;
                    if (o_GNT) o_ACK1 <= 1'b1;
                    else       o_ACK0 <= 1'b1;
                    r_state <= S_ACK;
                end
                S_RD: begin
                    o_MEM_RDEN <= 1'b0;
                    if (r_wait == c_WAIT_LAST) begin
                        if (o_GNT) begin
                            o_RDATA1 <= i_MEM_Q;
                            o_ACK1   <= 1'b1;
                        end else begin
                            o_RDATA0 <= i_MEM_Q;
                            o_ACK0   <= 1'b1;
                        end
                        r_state <= S_ACK;
                    end else begin
                        r_wait <= r_wait + 2'd1;
                    end
                end
                S_ACK: begin
                    o_ACK0  <= 1'b0;
                    o_ACK1  <= 1'b0;
                    o_BUSY  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_ram_port_arbiter.sv
//==============================================================================
// Module   : tb_ram_port_arbiter
// Brief    : Directed self-checking bench for ram_port_arbiter with behavioural
//            RAM models (RD_LAT = 2 main instance, RD_LAT = 3 second instance).
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_ram_port_arbiter;

    logic        r_clk = 1'b0;
    logic        r_rst_n = 1'b0;

    // Main instance (RD_LAT = 2)
    logic        r_req0 = 0, r_req1 = 0, r_we0 = 0, r_we1 = 0;
    logic [4:0]  r_addr0 = 0, r_addr1 = 0;
    logic [15:0] r_wdata0 = 0, r_wdata1 = 0;
    logic        w_ack0, w_ack1, w_wren, w_rden, w_busy, w_gnt;
    logic [15:0] w_rdata0, w_rdata1, w_mem_data;
    logic [4:0]  w_mem_addr;
    logic [15:0] r_qa;
    logic [15:0] mem_a [0:31];

    // Second instance (RD_LAT = 3), port 0 only
    logic        r_b_req0 = 0, r_b_we0 = 0;
    logic [4:0]  r_b_addr0 = 0;
    logic [15:0] r_b_wdata0 = 0;
    logic        r_zero = 0;
    logic [4:0]  r_zero_a = 0;
    logic [15:0] r_zero_d = 0;
    logic        w_b_ack0, w_b_ack1, w_b_wren, w_b_rden, w_b_busy, w_b_gnt;
    logic [15:0] w_b_rdata0, w_b_rdata1, w_b_mem_data;
    logic [4:0]  w_b_mem_addr;
    logic [15:0] r_qb1, r_qb2;
    logic [15:0] mem_b [0:31];

    int n_total = 0;
    int n_bad   = 0;
    int n_wren  = 0;
    int n_ovl   = 0;
    int ack_log[$];
    int gnt_log[$];

    always #5 r_clk = ~r_clk;

    ram_port_arbiter #(.ADDR_W(5), .DATA_W(16), .RD_LAT(2)) u_dut (
        .i_CLK(r_clk), .i_RST_N(r_rst_n),
        .i_REQ0(r_req0), .i_REQ1(r_req1), .i_WE0(r_we0), .i_WE1(r_we1),
        .i_ADDR0(r_addr0), .i_ADDR1(r_addr1),
        .i_WDATA0(r_wdata0), .i_WDATA1(r_wdata1),
        .o_ACK0(w_ack0), .o_ACK1(w_ack1),
        .o_RDATA0(w_rdata0), .o_RDATA1(w_rdata1),
        .o_MEM_ADDR(w_mem_addr), .o_MEM_DATA(w_mem_data),
        .o_MEM_WREN(w_wren), .o_MEM_RDEN(w_rden),
        .i_MEM_Q(r_qa), .o_BUSY(w_busy), .o_GNT(w_gnt)
    );

    ram_port_arbiter #(.ADDR_W(5), .DATA_W(16), .RD_LAT(3)) u_dut_b (
        .i_CLK(r_clk), .i_RST_N(r_rst_n),
        .i_REQ0(r_b_req0), .i_REQ1(r_zero), .i_WE0(r_b_we0), .i_WE1(r_zero),
        .i_ADDR0(r_b_addr0), .i_ADDR1(r_zero_a),
        .i_WDATA0(r_b_wdata0), .i_WDATA1(r_zero_d),
        .o_ACK0(w_b_ack0), .o_ACK1(w_b_ack1),
        .o_RDATA0(w_b_rdata0), .o_RDATA1(w_b_rdata1),
        .o_MEM_ADDR(w_b_mem_addr), .o_MEM_DATA(w_b_mem_data),
        .o_MEM_WREN(w_b_wren), .o_MEM_RDEN(w_b_rden),
        .i_MEM_Q(r_qb2), .o_BUSY(w_b_busy), .o_GNT(w_b_gnt)
    );

    // RAM models: address sampled one edge after it is driven, plus output stages
    always @(posedge r_clk) begin
        if (w_wren) mem_a[w_mem_addr] <= w_mem_data;
        r_qa <= mem_a[w_mem_addr];
        if (w_b_wren) mem_b[w_b_mem_addr] <= w_b_mem_data;
        r_qb1 <= mem_b[w_b_mem_addr];
        r_qb2 <= r_qb1;
    end

    // Monitors: ack order, grant id at ack, wren cycles, wren/rden overlap
    always @(negedge r_clk) begin
        if (w_ack0) begin ack_log.push_back(0); gnt_log.push_back(int'(w_gnt)); end
        if (w_ack1) begin ack_log.push_back(1); gnt_log.push_back(int'(w_gnt)); end
        if (w_wren) n_wren++;
        if ((w_wren && w_rden) || (w_b_wren && w_b_rden)) n_ovl++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // One port-0 transaction; n = negedges from request to observed ack
    task automatic p0_txn(input logic we, input logic [4:0] addr, input logic [15:0] wd,
                          output logic [15:0] rd, output int n);
        @(negedge r_clk);
        r_we0 = we; r_addr0 = addr; r_wdata0 = wd; r_req0 = 1'b1;
        n = 0;
        do begin @(negedge r_clk); n++; end while (!w_ack0 && n < 40);
        check("p0_ack_seen", w_ack0, 1'b1);
        rd = w_rdata0;
        @(posedge r_clk); #1 r_req0 = 1'b0;
    endtask

    task automatic p1_txn(input logic we, input logic [4:0] addr, input logic [15:0] wd,
                          output logic [15:0] rd, output int n);
        @(negedge r_clk);
        r_we1 = we; r_addr1 = addr; r_wdata1 = wd; r_req1 = 1'b1;
        n = 0;
        do begin @(negedge r_clk); n++; end while (!w_ack1 && n < 40);
        check("p1_ack_seen", w_ack1, 1'b1);
        rd = w_rdata1;
        @(posedge r_clk); #1 r_req1 = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge r_clk); r_rst_n = 1'b0;
        repeat (2) @(negedge r_clk);
        r_rst_n = 1'b1;
    endtask

    initial begin
        logic [15:0] d, d0, d1;
        int          n, n0, n1, wb;

        // Reset state
        repeat (3) @(negedge r_clk);
        r_rst_n = 1'b1;
        @(negedge r_clk);
        check("rst_ack", {w_ack0, w_ack1, w_b_ack0}, 3'b000);
        check("rst_rdata", {w_rdata0, w_rdata1}, 32'h0);
        check("rst_busy_gnt", {w_busy, w_gnt}, 2'b00);
        check("rst_mem", {w_wren, w_rden, w_mem_addr, w_mem_data}, 23'h0);

        // T1: port 0 write then read, single-cycle wren, read latency 2
        wb = n_wren;
        p0_txn(1'b1, 5'h01, 16'h0003, d, n);
        check("t1_wr_lat", n - 1, 1);
        check("t1_wren_cycles", n_wren - wb, 1);
        p0_txn(1'b0, 5'h01, 16'h0000, d, n);
        check("t1_rd_lat", n - 1, 2);
        check("t1_rdata0", d, 16'h0003);
        check("t1_rdata1", w_rdata1, 16'h0000);

        // T2: simultaneous requests right after reset, port 0 wins the tie
        do_reset();
        ack_log.delete(); gnt_log.delete();
        fork
            p0_txn(1'b1, 5'h02, 16'h0004, d0, n0);
            p1_txn(1'b0, 5'h02, 16'h0000, d1, n1);
        join
        check("t2_n_acks", ack_log.size(), 2);
        if (ack_log.size() > 0) check("t2_first_port", ack_log[0], 0);
        check("t2_rdata1", d1, 16'h0004);

        // T3: constant contention for 8 writes, strict alternation
        ack_log.delete(); gnt_log.delete();
        fork
            begin
                logic [15:0] da; int na;
                for (int i = 0; i < 4; i++) p0_txn(1'b1, 5'(8 + i), 16'(16'h0100 + i), da, na);
            end
            begin
                logic [15:0] db; int nb;
                for (int i = 0; i < 4; i++) p1_txn(1'b1, 5'(16 + i), 16'(16'h0200 + i), db, nb);
            end
        join
        check("t3_n_acks", ack_log.size(), 8);
        for (int i = 0; i < ack_log.size() && i < 8; i++) begin
            check("t3_ack_port", ack_log[i], i % 2);
            check("t3_gnt", gnt_log[i], i % 2);
        end

        // T4: port 1 alone, top address, no wrap
        p1_txn(1'b1, 5'h1F, 16'hFFFF, d, n);
        p1_txn(1'b1, 5'h00, 16'h1234, d, n);
        p1_txn(1'b0, 5'h1F, 16'h0000, d, n);
        check("t4_rdata1", d, 16'hFFFF);
        check("t4_rd_lat", n - 1, 2);
        check("t4_mem_addr", w_mem_addr, 5'h1F);
        check("t4_rdata0_held", w_rdata0, 16'h0000);
        p0_txn(1'b0, 5'h00, 16'h0000, d, n);
        check("t4_p0_rd00", d, 16'h1234);
        check("t4_rdata1_held", w_rdata1, 16'hFFFF);

        // T5: asynchronous reset during the read wait
        ack_log.delete(); gnt_log.delete();
        @(negedge r_clk);
        r_we0 = 1'b0; r_addr0 = 5'h01; r_req0 = 1'b1;
        @(negedge r_clk);
        check("t5_busy_before", {w_busy, w_rden}, 2'b11);
        #2 r_rst_n = 1'b0;
        #1;
        check("t5_async_clear", {w_busy, w_rden, w_wren, w_ack0, w_gnt}, 5'b0);
        check("t5_rdata0_clear", w_rdata0, 16'h0000);
        r_req0 = 1'b0;
        @(negedge r_clk); r_rst_n = 1'b1;
        repeat (4) @(negedge r_clk);
        check("t5_no_ack", ack_log.size(), 0);
        fork
            p0_txn(1'b1, 5'h03, 16'h0077, d0, n0);
            p1_txn(1'b1, 5'h04, 16'h0088, d1, n1);
        join
        if (ack_log.size() > 0) check("t5_tie_p0", ack_log[0], 0);
        p1_txn(1'b0, 5'h03, 16'h0000, d, n);
        check("t5_rd_after", d, 16'h0077);

        // T6: RD_LAT = 3 instance, preload 0xABCD @0x05 then read it back
        @(negedge r_clk);
        r_b_we0 = 1'b1; r_b_addr0 = 5'h05; r_b_wdata0 = 16'hABCD; r_b_req0 = 1'b1;
        n = 0;
        do begin @(negedge r_clk); n++; end while (!w_b_ack0 && n < 40);
        check("t6_wr_ack", w_b_ack0, 1'b1);
        @(posedge r_clk); #1 r_b_req0 = 1'b0;
        @(negedge r_clk);
        r_b_we0 = 1'b0; r_b_req0 = 1'b1;
        n = 0;
        do begin @(negedge r_clk); n++; end while (!w_b_ack0 && n < 40);
        check("t6_rd_ack", w_b_ack0, 1'b1);
        check("t6_rd_lat", n - 1, 3);
        check("t6_rdata", w_b_rdata0, 16'hABCD);
        @(posedge r_clk); #1 r_b_req0 = 1'b0;

        repeat (3) @(negedge r_clk);
        check("wren_rden_overlap", n_ovl, 0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/ram_port_arbiter.md
Name: ram_port_arbiter

Overview:
- Shares the single-port 32x16 on-chip RAM between two independent requesters (port 0, port 1).
- Each requester issues one read or one write per req/ack transaction; the block owns the RAM address, data, wren and rden pins.
- Fair round-robin arbitration; reads return data in a holding register alongside the ack.
- Sits between the RAM instance and the datapath sequencers (adder FSM, debug/HEX readback).

Parameters:
- ADDR_W, 5, RAM address width (depth 2**ADDR_W).
- DATA_W, 16, RAM word width.
- RD_LAT, 2, cycles from the edge that drives o_MEM_ADDR/o_MEM_RDEN to the edge that samples i_MEM_Q; legal range 1..4.

Ports:
- i_CLK  in  1  system clock, all logic on the rising edge.
- i_RST_N  in  1  asynchronous, active-low reset.
- i_REQ0 / i_REQ1  in  1  transaction request, port 0 / port 1.
- i_WE0 / i_WE1  in  1  1 = write, 0 = read.
- i_ADDR0 / i_ADDR1  in  ADDR_W  target address.
- i_WDATA0 / i_WDATA1  in  DATA_W  write data.
- o_ACK0 / o_ACK1  out  1  one-cycle completion pulse.
- o_RDATA0 / o_RDATA1  out  DATA_W  read result; valid with ack, held until the next read on that port.
- o_MEM_ADDR  out  ADDR_W  to RAM address.
- o_MEM_DATA  out  DATA_W  to RAM data.
- o_MEM_WREN  out  1  to RAM wren.
- o_MEM_RDEN  out  1  to RAM rden.
- i_MEM_Q  in  DATA_W  from RAM q.
- o_BUSY  out  1  high in any state other than IDLE.
- o_GNT  out  1  id of the current or last granted port (HEX/debug).

Behaviour:
- Reset (async, i_RST_N = 0): state IDLE; all outputs 0; RR pointer set so port 0 wins the first tie.
- Registered outputs: all outputs are registers; no combinational path from inputs to outputs.
- Handshake:
  - Requester holds req/we/addr/wdata stable from assertion until it samples ack = 1.
  - It must drop req on the edge after the ack. If req is still high in IDLE, that is a new transaction.
- States:
  - IDLE: sample requests. If none, stay. If one, grant it. If both, grant the port that is not o_GNT.
    - On grant: latch addr and wdata into o_MEM_ADDR/o_MEM_DATA; set o_MEM_WREN = we or o_MEM_RDEN = !we; set o_GNT = winner; o_BUSY = 1.
    - Next state: WR if we, else RD.
  - WR: clear o_MEM_WREN (exactly one wren cycle); assert o_ACKn for the winner; go to ACK.
  - RD: clear o_MEM_RDEN after one cycle. Count a wait counter up to RD_LAT-1 cycles after the grant edge.
    - On the RD_LAT-th edge after the grant edge: o_RDATAn <= i_MEM_Q and o_ACKn <= 1; go to ACK.
  - ACK: clear o_ACKn and o_BUSY; go to IDLE. Requests are not sampled in ACK.
- Latency:
  - Write: ack high for the cycle after edge G+1 (G = grant edge).
  - Read: ack high for the cycle after edge G+RD_LAT.
  - Minimum spacing between grants: 3 cycles for a write, RD_LAT+2 cycles for a read.
- Fairness:
  - The RR pointer is o_GNT itself, updated only on grant.
  - Under constant contention, grants strictly alternate 0,1,0,1.
  - A lone requester may win repeatedly.
- Boundaries:
  - Address ADDR_W'h1F is legal; no wrap or translation.
  - o_RDATA of the non-granted port never changes.
  - o_MEM_WREN and o_MEM_RDEN are never high together, and never high outside WR/RD.
  - Reset asserted mid-transaction: pending ack is dropped; wren/rden go low immediately; the requester must re-issue.
  - req deasserted before ack (protocol violation): the transaction still completes and acks.

Test Plan:
- Port 0 write 0x0003 @0x01, then port 0 read @0x01 → wren high exactly 1 cycle; read ack at G+2 with o_RDATA0 = 0x0003; o_RDATA1 unchanged at 0.
- Both ports request on the same cycle after reset (P0 write 0x0004 @0x02, P1 read @0x02) → P0 granted first; P1 then reads o_RDATA1 = 0x0004.
- Both reqs held continuously for 8 transactions → o_GNT sequence 0,1,0,1,0,1,0,1; no two consecutive acks on the same port.
- Port 1 alone: back-to-back writes 0xFFFF @0x1F and 0x1234 @0x00, then read @0x1F → returns 0xFFFF; address 0x1F handled without wrap.
- RD_LAT = 3 build, read @0x05 pre-loaded 0xABCD → ack exactly 3 edges after grant with data 0xABCD.
- i_RST_N pulsed low during the RD wait → outputs 0 asynchronously; no ack issued; o_BUSY = 0; next request is serviced normally, with port 0 winning a tie.
